muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO registers for the MIPS core.

---
 rtl/muldiv_unit_pkg.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 12 +
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes, FSM encodings, decode helper.
package muldiv_unit_pkg;

   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned STATE_W = 2;

   localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
   localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
   localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
   localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
   localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
   localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
   localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
   localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

   localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
   localparam logic [STATE_W-1:0] S_FIX  = 2'd2;

   // MULT, MULTU, DIV and DIVU occupy 6'h18..6'h1B; bit 1 selects divide, bit 0 unsigned.
   function automatic logic is_muldiv(input logic [FUNCT_W-1:0] f);
      return f[5:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitude and result sign fix.
module muldiv_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y_c
);

   assign y_c = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO; shift-add multiply, restoring divide.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic               illegal,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic [WIDTH-1:0]   rd_data
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned ACC_W = 2 * WIDTH;

   logic [STATE_W-1:0] state, state_nxt;
   logic               busy_nxt, done_nxt, illegal_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [WIDTH-1:0]   mreg, mreg_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               is_div, is_div_nxt;
   logic               neg_q, neg_q_nxt;
   logic               neg_r, neg_r_nxt;

   logic               signed_op;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [ACC_W-1:0]   prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [ACC_W-1:0]   mul_step;
   logic [WIDTH:0]     div_sh, div_diff;
   logic [ACC_W-1:0]   div_step;

   assign signed_op = ~funct[0];

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(signed_op & a[WIDTH-1]), .y_c(a_abs));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(signed_op & b[WIDTH-1]), .y_c(b_abs));
   muldiv_sign_fix #(.WIDTH(ACC_W)) u_fix_p (.x(acc), .neg(neg_q), .y_c(prod_fix));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.x(acc[WIDTH-1:0]), .neg(neg_q), .y_c(quo_fix));
   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.x(acc[ACC_W-1:WIDTH]), .neg(neg_r), .y_c(rem_fix));

   // acc = {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
   always_comb begin
      mul_add  = acc[0] ? mreg : WIDTH'(0);
      mul_sum  = {1'b0, acc[ACC_W-1:WIDTH]} + {1'b0, mul_add};
      mul_step = {mul_sum, acc[WIDTH-1:1]};
      div_sh   = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_sh - {1'b0, mreg};
      div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   assign rd_data = (funct == FUNCT_MFHI) ? hi :
                    (funct == FUNCT_MFLO) ? lo : WIDTH'(0);

   always_comb begin
      state_nxt   = state;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      illegal_nxt = 1'b0;
      hi_nxt      = hi;
      lo_nxt      = lo;
      acc_nxt     = acc;
      mreg_nxt    = mreg;
      cnt_nxt     = cnt;
      is_div_nxt  = is_div;
      neg_q_nxt   = neg_q;
      neg_r_nxt   = neg_r;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (funct == FUNCT_MTHI) begin
                  hi_nxt = a;
               end else if (funct == FUNCT_MTLO) begin
                  lo_nxt = a;
               end else if (is_muldiv(funct)) begin
                  busy_nxt   = 1'b1;
                  cnt_nxt    = CNT_W'(0);
                  is_div_nxt = funct[1];
                  mreg_nxt   = b_abs;
                  // Divide by zero bypasses RUN: FIX passes acc straight to {hi,lo}.
                  if (funct[1] && (b == WIDTH'(0))) begin
                     acc_nxt   = {a, {WIDTH{1'b1}}};
                     neg_q_nxt = 1'b0;
                     neg_r_nxt = 1'b0;
                     state_nxt = S_FIX;
                  end else begin
                     acc_nxt   = {WIDTH'(0), a_abs};
                     neg_q_nxt = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_r_nxt = signed_op & a[WIDTH-1];
                     state_nxt = S_RUN;
                  end
               end else if ((funct != FUNCT_MFHI) && (funct != FUNCT_MFLO)) begin
                  illegal_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            acc_nxt = is_div ? div_step : mul_step;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            if (is_div) begin
               hi_nxt = rem_fix;
               lo_nxt = quo_fix;
            end else begin
               hi_nxt = prod_fix[ACC_W-1:WIDTH];
               lo_nxt = prod_fix[WIDTH-1:0];
            end
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         illegal <= 1'b0;
         hi      <= WIDTH'(0);
         lo      <= WIDTH'(0);
         acc     <= ACC_W'(0);
         mreg    <= WIDTH'(0);
         cnt     <= CNT_W'(0);
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         illegal <= illegal_nxt;
         hi      <= hi_nxt;
         lo      <= lo_nxt;
         acc     <= acc_nxt;
         mreg    <= mreg_nxt;
         cnt     <= cnt_nxt;
         is_div  <= is_div_nxt;
         neg_q   <= neg_q_nxt;
         neg_r   <= neg_r_nxt;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at issue, compared on done.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] a, b;
   logic        busy, done, illegal;
   logic [31:0] hi, lo, rd_data;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] sb[$];

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
      .busy(busy), .done(done), .illegal(illegal), .hi(hi), .lo(lo), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, q, r;
      longint unsigned ux, uy, uq, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      if (f == FUNCT_MULT)  return 64'(sx * sy);
      if (f == FUNCT_MULTU) return ux * uy;
      if (y == 32'd0)       return {x, 32'hFFFF_FFFF};
      if (f == FUNCT_DIV) begin
         q = sx / sy;
         r = sx % sy;
         return {r[31:0], q[31:0]};
      end
      uq = ux / uy;
      ur = ux % uy;
      return {ur[31:0], uq[31:0]};
   endfunction

   // Result monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      logic [63:0] exp;
      forever begin
         @(posedge clk);
         #2;
         if (done === 1'b1) begin
            if (sb.size() == 0) check("unexpected_done", 64'(1), 64'(0));
            else begin
               exp = sb.pop_front();
               check("hilo", {hi, lo}, exp);
            end
         end
      end
   end

   task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                         input int lat, input int poke_at, input logic [5:0] poke_f);
      int n, nb;
      logic ill;
      logic [63:0] prev;
      prev  = {hi, lo};
      start = 1'b1;
      funct = f;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back(model(f, x, y));
      n   = 0;
      nb  = busy ? 1 : 0;
      ill = 1'b0;
      while (done !== 1'b1 && n < 100) begin
         if (n == poke_at) begin
            start = 1'b1;
            funct = poke_f;
            a     = 32'h1111_1111;
            b     = 32'h0000_0000;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
         if (busy === 1'b1) nb++;
         if (illegal === 1'b1) ill = 1'b1;
         if (n == 10 && lat > 10) check("hold_during_run", {hi, lo}, prev);
      end
      start = 1'b0;
      check("latency", 64'(n), 64'(lat));
      check("busy_cycles", 64'(nb), 64'(lat));
      check("no_illegal", 64'(ill), 64'(0));
   endtask

   initial begin
      logic [5:0]  rf;
      logic [31:0] ra, rb;
      reset = 1'b1;
      start = 1'b0;
      funct = 6'h00;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_illegal", 64'(illegal), 64'(0));
      check("rst_hilo", {hi, lo}, 64'(0));
      reset = 1'b0;

      run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1, 6'h0);
      run_op(FUNCT_MULT,  32'hFFFF_FFFD, 32'd7,         33, -1, 6'h0);
      run_op(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2,         33, -1, 6'h0);
      run_op(FUNCT_DIVU,  32'd100,       32'd7,         33, -1, 6'h0);
      run_op(FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, -1, 6'h0);
      run_op(FUNCT_DIVU,  32'd5,         32'd0,          1, -1, 6'h0);
      run_op(FUNCT_DIV,   32'hFFFF_FFF0, 32'd0,          1, -1, 6'h0);
      run_op(FUNCT_DIV,   32'd7,         32'hFFFF_FFFE, 33, -1, 6'h0);
      // Starts while busy must be ignored: a div-by-zero and an illegal funct.
      run_op(FUNCT_MULT,  32'h0001_2345, 32'hFFFF_FF00, 33,  5, FUNCT_DIVU);
      run_op(FUNCT_DIVU,  32'hDEAD_BEEF, 32'd3,         33, 20, 6'h20);

      for (int i = 0; i < 8; i++) begin
         rf = 6'h18 + 6'(i % 4);
         ra = $urandom;
         rb = (i == 6) ? 32'd0 : $urandom;
         run_op(rf, ra, rb, ((rf[1] == 1'b1) && (rb == 32'd0)) ? 1 : 33, -1, 6'h0);
      end

      // MTHI/MTLO write directly, no busy and no done.
      start = 1'b1;
      funct = FUNCT_MTHI;
      a     = 32'd1234;
      @(posedge clk);
      #1;
      check("mthi_hi", 64'(hi), 64'(1234));
      check("mthi_busy", 64'(busy), 64'(0));
      funct = FUNCT_MTLO;
      a     = 32'd5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("mtlo_lo", 64'(lo), 64'(5678));
      check("mthi_keep", 64'(hi), 64'(1234));
      funct = FUNCT_MFHI;
      #1;
      check("mfhi", 64'(rd_data), 64'(1234));
      funct = FUNCT_MFLO;
      #1;
      check("mflo", 64'(rd_data), 64'(5678));
      funct = FUNCT_MULT;
      #1;
      check("rd_other", 64'(rd_data), 64'(0));

      start = 1'b1;
      funct = 6'h20;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("illegal_pulse", 64'(illegal), 64'(1));
      check("illegal_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      check("illegal_clear", 64'(illegal), 64'(0));

      // Reset mid-MULT: no expectation queued, so any done pulse is flagged by the monitor.
      start = 1'b1;
      funct = FUNCT_MULT;
      a     = 32'd99;
      b     = 32'd77;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_hilo", {hi, lo}, 64'(0));
      repeat (40) @(posedge clk);
      #3;
      check("abort_idle", 64'(busy), 64'(0));
      check("sb_empty", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
